// File: rtl/mq_dec_cu_if.sv
// Bus bundle for mq_dec_cu: byte lookahead fill, decode commands and status.
// Handshakes: a byte transfers on the rising edge where byte_valid && byte_ready; a command
// transfers where cmd_valid && cmd_ready. Producers hold payload stable while valid is high.
interface mq_dec_cu_if #(
    parameter int CW = 32
);
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_sub;
    logic [15:0]   cmd_qe;
    logic [3:0]    cmd_shift;
    logic          done;
    logic [15:0]   chigh;
    logic [3:0]    ct;
    logic          marker;
    logic [31:0]   bytes_used;
    logic [2:0]    state_dbg;
    logic [CW-1:0] c_dbg;

    modport master (
        output start, byte_in, byte_valid, cmd_valid, cmd_sub, cmd_qe, cmd_shift,
        input  byte_ready, cmd_ready, done, chigh, ct, marker, bytes_used, state_dbg, c_dbg
    );

    modport slave (
        input  start, byte_in, byte_valid, cmd_valid, cmd_sub, cmd_qe, cmd_shift,
        output byte_ready, cmd_ready, done, chigh, ct, marker, bytes_used, state_dbg, c_dbg
    );
endinterface

// File: rtl/mq_dec_cu.sv
// MQ decoder C-register / byte-input unit: INITDEC, BYTEIN with unstuffing and marker
// detection, and the C/CT half of RENORMD. Optional byte counter under MQD_BYTE_COUNT_EN.
module mq_dec_cu #(
    parameter logic [7:0] MARKER_THRESH = 8'h8F,
    parameter int         CW            = 32
) (
    input logic        clk,
    input logic        rst,
    mq_dec_cu_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT0, S_INIT1, S_INIT2, S_READY, S_SHIFT, S_BYTEIN
    } state_t;

    localparam logic [CW-1:0] FF00 = CW'(16'hFF00);

    state_t        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [3:0]    ct_q, ct_d;
    logic [3:0]    rem_q, rem_d;
    logic [7:0]    b_q, b_d;
    logic [7:0]    l_q, l_d;
    logic          lv_q, lv_d;
    logic          mk_q, mk_d;
    logic          done_q, done_d;
    logic          restart;
    logic          byte_ready;
    logic [3:0]    k;

    logic [CW-1:0] bi_c;
    logic [3:0]    bi_ct;
    logic [7:0]    bi_b;
    logic          bi_take, bi_mk, bi_stall;

    assign byte_ready = !lv_q && !mk_q && (state_q != S_IDLE);

    // BYTEIN outcome for the current B/L/mk; once a marker is seen, 1-bits are fed forever.
    always_comb begin
        bi_c     = c_q + FF00;
        bi_ct    = 4'd8;
        bi_b     = b_q;
        bi_take  = 1'b0;
        bi_mk    = mk_q;
        bi_stall = 1'b0;
        if (mk_q) begin
            bi_mk = 1'b1;
        end else if (!lv_q) begin
            bi_stall = 1'b1;
            bi_c     = c_q;
        end else if (b_q == 8'hFF && l_q > MARKER_THRESH) begin
            bi_mk = 1'b1;
        end else if (b_q == 8'hFF) begin
            bi_c    = c_q + (CW'(l_q) << 9);
            bi_ct   = 4'd7;
            bi_b    = l_q;
            bi_take = 1'b1;
        end else begin
            bi_c    = c_q + (CW'(l_q) << 8);
            bi_b    = l_q;
            bi_take = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        ct_d    = ct_q;
        rem_d   = rem_q;
        b_d     = b_q;
        l_d     = l_q;
        lv_d    = lv_q;
        mk_d    = mk_q;
        done_d  = 1'b0;
        restart = 1'b0;
        k       = 4'd0;

        if (bus.byte_valid && byte_ready) begin
            l_d  = bus.byte_in;
            lv_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) restart = 1'b1;
            end
            S_INIT0: begin
                if (lv_q) begin
                    b_d     = l_q;
                    lv_d    = 1'b0;
                    c_d     = CW'(l_q) << 16;
                    state_d = S_INIT1;
                end
            end
            S_INIT1, S_BYTEIN: begin
                if (!bi_stall) begin
                    c_d     = bi_c;
                    ct_d    = bi_ct;
                    b_d     = bi_b;
                    mk_d    = bi_mk;
                    if (bi_take) lv_d = 1'b0;
                    state_d = (state_q == S_INIT1) ? S_INIT2 : S_SHIFT;
                end
            end
            S_INIT2: begin
                c_d     = c_q << 7;
                ct_d    = ct_q - 4'd7;
                state_d = S_READY;
                done_d  = 1'b1;
            end
            S_READY: begin
                if (bus.start) begin
                    restart = 1'b1;
                end else if (bus.cmd_valid) begin
                    if (bus.cmd_sub) c_d[CW-1:CW-16] = c_q[CW-1:CW-16] - bus.cmd_qe;
                    rem_d = bus.cmd_shift;
                    if (bus.cmd_shift == 4'd0) done_d = 1'b1;
                    else                       state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Shift as far as the buffered bits allow; refill only if more shifting remains.
                k     = (rem_q < ct_q) ? rem_q : ct_q;
                c_d   = c_q << k;
                ct_d  = ct_q - k;
                rem_d = rem_q - k;
                if (rem_d == 4'd0) begin
                    state_d = S_READY;
                    done_d  = 1'b1;
                end else if (ct_d == 4'd0) begin
                    state_d = S_BYTEIN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (restart) begin
            state_d = S_INIT0;
            lv_d    = 1'b0;
            mk_d    = 1'b0;
            c_d     = '0;
            ct_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            ct_q    <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            l_q     <= '0;
            lv_q    <= 1'b0;
            mk_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            ct_q    <= ct_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            l_q     <= l_d;
            lv_q    <= lv_d;
            mk_q    <= mk_d;
            done_q  <= done_d;
        end
    end

`ifdef MQD_BYTE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        consume;

    assign consume = ((state_q == S_INIT0) && lv_q) ||
                     (((state_q == S_INIT1) || (state_q == S_BYTEIN)) && bi_take);

    always_comb begin
        cnt_d = cnt_q;
        if (restart)                      cnt_d = '0;
        else if (consume && cnt_q != '1)  cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.bytes_used = cnt_q;
`else
    assign bus.bytes_used = '0;
`endif

    assign bus.cmd_ready  = (state_q == S_READY);
    assign bus.byte_ready = byte_ready;
    assign bus.done       = done_q;
    assign bus.chigh      = c_q[CW-1:CW-16];
    assign bus.ct         = ct_q;
    assign bus.marker     = mk_q;
    assign bus.state_dbg  = state_q;
    assign bus.c_dbg      = c_q;
endmodule

// File: tb/tb_mq_dec_cu.sv
// Bench for mq_dec_cu: directed stream cases plus randomized sessions checked against a
// bit-at-a-time MQ RENORMD/BYTEIN model of the decoder C register.
module tb_mq_dec_cu;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mq_dec_cu_if #(.CW(CW)) bus ();
    mq_dec_cu #(.MARKER_THRESH(8'h8F), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  feed_q[$];
    bit          feed_on;
    int          gap_pct;
    logic [15:0] exp_q[$];

    // reference model state
    logic [7:0]  m_s[$];
    logic [31:0] m_c;
    int          m_ct;
    logic [7:0]  m_b;
    bit          m_mk;
    int          m_used;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_bytein();
        if (m_mk) begin
            m_c  = m_c + 32'hFF00;
            m_ct = 8;
        end else if (m_b == 8'hFF && m_s[0] > 8'h8F) begin
            m_c  = m_c + 32'hFF00;
            m_ct = 8;
            m_mk = 1'b1;
        end else if (m_b == 8'hFF) begin
            m_b  = m_s.pop_front();
            m_used++;
            m_c  = m_c + (32'(m_b) << 9);
            m_ct = 7;
        end else begin
            m_b  = m_s.pop_front();
            m_used++;
            m_c  = m_c + (32'(m_b) << 8);
            m_ct = 8;
        end
    endfunction

    function automatic void m_init();
        m_mk   = 1'b0;
        m_b    = m_s.pop_front();
        m_used = 1;
        m_c    = 32'(m_b) << 16;
        m_ct   = 0;
        m_bytein();
        m_c  = m_c << 7;
        m_ct = m_ct - 7;
    endfunction

    function automatic void m_cmd(input bit sub, input logic [15:0] qe, input int n);
        if (sub) m_c = {m_c[31:16] - qe, m_c[15:0]};
        for (int i = 0; i < n; i++) begin
            if (m_ct == 0) m_bytein();
            m_c  = m_c << 1;
            m_ct = m_ct - 1;
        end
    endfunction

    function automatic int exp_used();
`ifdef MQD_BYTE_COUNT_EN
        return m_used;
`else
        return 0;
`endif
    endfunction

    // One clock: drive the byte feeder, note a fill, advance to the next falling edge.
    task automatic tick();
        if (feed_on && feed_q.size() != 0 && $urandom_range(99, 0) >= gap_pct) begin
            bus.byte_valid = 1'b1;
            bus.byte_in    = feed_q[0];
        end else begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'h00;
        end
        #1;
        if (!rst && bus.byte_valid && bus.byte_ready) feed_q.delete(0);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < limit) begin
            if (bus.done) ok = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
    endtask

    task automatic cmp(input string tag);
        check({tag, " ct"},     32'(bus.ct),         32'(m_ct));
        check({tag, " marker"}, 32'(bus.marker),     32'(m_mk));
        check({tag, " c"},      bus.c_dbg,           m_c);
        check({tag, " used"},   bus.bytes_used,      32'(exp_used()));
    endtask

    task automatic push_byte(input logic [7:0] v);
        feed_q.push_back(v);
        m_s.push_back(v);
    endtask

    task automatic clear_streams();
        feed_q.delete();
        m_s.delete();
    endtask

    task automatic do_init(input string tag);
        int cyc;
        bit ok;
        feed_on   = 1'b0;
        bus.start = 1'b1;
        tick();
        feed_on = 1'b1;
        m_init();
        exp_q.push_back(m_c[31:16]);
        wait_done(200, cyc, ok);
        check({tag, " done"}, 32'(ok), 32'd1);
        check({tag, " chigh"}, 32'(bus.chigh), 32'(exp_q.pop_front()));
        cmp(tag);
    endtask

    task automatic issue_cmd(input string tag, input bit sub, input logic [15:0] qe,
                             input logic [3:0] n, output int cyc);
        bit ok;
        check({tag, " rdy"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_sub   = sub;
        bus.cmd_qe    = qe;
        bus.cmd_shift = n;
        m_cmd(sub, qe, int'(n));
        exp_q.push_back(m_c[31:16]);
        tick();
        wait_done(200, cyc, ok);
        check({tag, " done"}, 32'(ok), 32'd1);
        check({tag, " chigh"}, 32'(bus.chigh), 32'(exp_q.pop_front()));
        cmp(tag);
    endtask

    initial begin
        int cyc;
        int seen;
        bit ok;
        logic [7:0] v;
        logic [15:0] qe;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_sub    = 1'b0;
        bus.cmd_qe     = 16'h0000;
        bus.cmd_shift  = 4'd0;
        feed_on        = 1'b0;
        gap_pct        = 0;
        @(negedge clk);
        tick();
        tick();
        check("rst chigh", 32'(bus.chigh), 32'd0);
        check("rst ct", 32'(bus.ct), 32'd0);
        check("rst ready", {30'd0, bus.cmd_ready, bus.byte_ready}, 32'd0);
        check("rst done", {30'd0, bus.done, bus.marker}, 32'd0);
        check("rst used", bus.bytes_used, 32'd0);
        rst = 1'b0;
        tick();

        // Plain stream 12,34,56
        clear_streams();
        push_byte(8'h12); push_byte(8'h34); push_byte(8'h56);
        do_init("d1 init");
        check("d1 init c", bus.c_dbg, 32'h091A0000);
        check("d1 init ct", 32'(bus.ct), 32'd1);
        issue_cmd("d1 sh3", 1'b0, 16'h0000, 4'd3, cyc);
        check("d1 sh3 c", bus.c_dbg, 32'h48D15800);
        check("d1 sh3 ct", 32'(bus.ct), 32'd6);
        check("d1 sh3 lat", 32'(cyc), 32'd3);
        tick();
        check("d1 done pulse", 32'(bus.done), 32'd0);

        // Subtract only, restart from READY
        clear_streams();
        push_byte(8'h12); push_byte(8'h34); push_byte(8'h56);
        do_init("d1b init");
        issue_cmd("d1b sub", 1'b1, 16'h0601, 4'd0, cyc);
        check("d1b sub chigh", 32'(bus.chigh), 32'h0319);
        check("d1b sub ct", 32'(bus.ct), 32'd1);
        check("d1b sub lat", 32'(cyc), 32'd0);

        // Stuffed 0xFF followed by 7F
        clear_streams();
        push_byte(8'hFF); push_byte(8'h7F); push_byte(8'h33);
        do_init("d2 init");
        check("d2 init c", bus.c_dbg, 32'h7FFF0000);
        issue_cmd("d2 sh1", 1'b0, 16'h0000, 4'd1, cyc);
        check("d2 sh1 c", bus.c_dbg, 32'hFFFE6600);

        // Marker FF,90
        clear_streams();
        push_byte(8'hFF); push_byte(8'h90);
        do_init("d3 init");
        check("d3 init c", bus.c_dbg, 32'h7FFF8000);
        check("d3 marker", 32'(bus.marker), 32'd1);
        check("d3 brdy", 32'(bus.byte_ready), 32'd0);
        issue_cmd("d3 sh3", 1'b0, 16'h0000, 4'd3, cyc);
        check("d3 sh3 c", bus.c_dbg, 32'hFFFFFC00);
        check("d3 brdy2", 32'(bus.byte_ready), 32'd0);

        // Starvation during BYTEIN
        clear_streams();
        push_byte(8'h12); push_byte(8'h34);
        m_s.push_back(8'h56);
        do_init("d4 init");
        bus.cmd_valid = 1'b1;
        bus.cmd_sub   = 1'b0;
        bus.cmd_shift = 4'd3;
        m_cmd(1'b0, 16'h0000, 3);
        tick();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) seen++;
            tick();
        end
        check("d4 stall done", 32'(seen), 32'd0);
        check("d4 stall c", bus.c_dbg, 32'h12340000);
        feed_q.push_back(8'h56);
        wait_done(50, cyc, ok);
        check("d4 done", 32'(ok), 32'd1);
        check("d4 c", bus.c_dbg, 32'h48D15800);
        cmp("d4");

        // Reset in the middle of SHIFT
        feed_on       = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_shift = 4'd2;
        tick();
        check("d5 pre done", 32'(bus.done), 32'd0);
        rst = 1'b1;
        tick();
        check("d5 rst chigh", 32'(bus.chigh), 32'd0);
        check("d5 rst ct", 32'(bus.ct), 32'd0);
        check("d5 rst flags", {28'd0, bus.cmd_ready, bus.byte_ready, bus.done, bus.marker}, 32'd0);
        check("d5 rst used", bus.bytes_used, 32'd0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done) seen++;
        end
        check("d5 no done", 32'(seen), 32'd0);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            gap_pct = int'($urandom_range(50, 0));
            clear_streams();
            for (int i = 0; i < 64; i++) begin
                case ($urandom_range(9, 0))
                    0, 1:    v = 8'hFF;
                    2:       v = ($urandom_range(1, 0) != 0) ? 8'h8F : 8'h90;
                    default: v = 8'($urandom_range(255, 0));
                endcase
                push_byte(v);
            end
            do_init("rnd init");
            for (int c = 0; c < 15; c++) begin
                qe = 16'($urandom_range(32'(m_c[31:16]), 0));
                issue_cmd("rnd cmd", 1'($urandom_range(1, 0)), qe,
                          4'($urandom_range(15, 0)), cyc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mq_dec_cu.md
Name: mq_dec_cu

Overview:
- C-register and byte-input unit of the MQ arithmetic decoder; the decode-side counterpart of the encoder C/carry/byte-out path.
- Performs INITDEC, BYTEIN (with 0xFF bit-unstuffing and marker detection) and the C/CT half of RENORMD.
- Exposes Chigh to the interval unit, which compares it against Qe and issues subtract/shift commands.
- Bytes arrive from the bitstream buffer over a valid/ready handshake into a one-byte lookahead register.

Parameters:
- MARKER_THRESH, 8'h8F, byte following 0xFF greater than this is a marker.
- CW, 32, C register width; Chigh = C[CW-1:CW-16].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begin INITDEC (honoured in IDLE or READY only)
- byte_in  in  8  compressed byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  lookahead empty, not marker, state != IDLE
- cmd_valid  in  1  decode command; accepted only when cmd_ready
- cmd_ready  out  1  high in READY
- cmd_sub  in  1  subtract cmd_qe from Chigh before shifting
- cmd_qe  in  16  Qe value
- cmd_shift  in  4  renormalisation shift count 0..15 (LZ of A)
- done  out  1  one-cycle pulse: command or INITDEC complete
- chigh  out  16  C[CW-1:CW-16]
- ct  out  4  bit counter 0..8
- marker  out  1  marker detected; sticky until start/rst
- bytes_used  out  32  consumed-byte count (see Optional Feature)

Behaviour:
- Registers: C, CT, B (last consumed byte), L (lookahead), lv (L valid), mk (marker), rem (shifts left), state.
- Reset values: C=0, CT=0, B=0, lv=0, mk=0, rem=0, state=IDLE; outputs cmd_ready=0, done=0, byte_ready=0, marker=0, chigh=0, ct=0, bytes_used=0.
- Byte fill: on byte_valid && byte_ready, L<=byte_in and lv<=1. Because byte_ready requires lv=0, fill and consume never occur in the same cycle.
- States: IDLE, INIT0, INIT1, INIT2, READY, SHIFT, BYTEIN.
- IDLE: start -> INIT0; clear lv, mk, C, CT.
- INIT0: wait lv; then B<=L, lv<=0, C<=L<<16 -> INIT1.
- INIT1: perform the BYTEIN operation (below) -> INIT2; stall while it needs L and lv=0.
- INIT2: C<<=7, CT-=7 -> READY; done=1.
- READY: cmd_ready=1. On cmd_valid:
  - if cmd_sub, Chigh<=Chigh-cmd_qe, mod 2^16; the interval unit guarantees Chigh>=cmd_qe.
  - rem<=cmd_shift.
  - cmd_shift=0 -> done next cycle, stay READY; otherwise -> SHIFT.
- SHIFT: k=min(rem,CT); C<<=k (zeros in, MSBs discarded), CT-=k, rem-=k.
  - rem reaches 0 -> READY, done=1.
  - else if CT=0 -> BYTEIN.
  - Entry with CT=0 shifts 0 bits and goes to BYTEIN.
- BYTEIN operation (one cycle when data available):
  - mk=1: C+=16'hFF00, CT=8; no consume.
  - B=8'hFF and lv and L>MARKER_THRESH: C+=16'hFF00, CT=8, mk<=1; L not consumed.
  - B=8'hFF and lv and L<=MARKER_THRESH: B<=L, lv<=0, C+=L<<9, CT=7.
  - B!=8'hFF and lv: B<=L, lv<=0, C+=L<<8, CT=8.
  - lv=0 and mk=0: stall; state and C hold.
  - Returns to SHIFT; C additions are modulo 2^CW.
- Start in READY restarts INITDEC: lv<=0, mk<=0; the buffer re-presents the stream. Start in any other state is ignored.
- Reset mid-command aborts immediately to reset values; no done pulse.
- cmd_valid outside READY is ignored.
- Latency: a shift of n bits with no byte boundary takes 1 cycle in SHIFT. Each BYTEIN adds one cycle plus any stall.

Optional Feature:
- Macro MQD_BYTE_COUNT_EN.
- Defined: bytes_used increments on every B<=L consume (INIT0 and non-marker BYTEIN); cleared by rst/start; saturates at 2^32-1.
- Undefined: counter logic absent, bytes_used tied to 0.

Test Plan:
- Init on stream 12,34,56: start -> done after INIT2; chigh=16'h091A, ct=1, C=32'h091A0000, B=34.
- From above, cmd_shift=3, cmd_sub=0 -> SHIFT(1 bit), BYTEIN(56), SHIFT(2 bits); done; C=32'h48D15800, ct=6.
- Sub only: chigh=16'h091A, cmd_sub=1, cmd_qe=16'h0601, cmd_shift=0 -> done next cycle, chigh=16'h0319, ct unchanged.
- Stuffed byte, stream FF,7F -> after init C=32'h7FFF0000, ct=0, marker=0. A following shift of 1 triggers BYTEIN of the next byte with B=7F (<<8 path).
- Marker, stream FF,90 -> C=32'h7FFF8000, ct=1, marker=1, byte_ready=0 thereafter. Subsequent BYTEINs add FF00 without handshake.
- Starvation and reset: withhold byte_valid during BYTEIN for 5 cycles -> no done, C held; then supply byte -> completes. Assert rst mid-SHIFT -> all outputs at reset values next cycle.
